// File: rtl/seq_alu.sv
// Multi-cycle ALU for the multi-cycle RISC-V datapath.
// Base integer ops and shifts finish in one cycle. MUL/MULHU/DIV/DIVU/REM/REMU
// run an iterative one-bit-per-cycle engine behind a start/busy/done handshake.
module seq_alu #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       opc,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    state_t               state_q, state_d;
    logic [SHW-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opd_q, opd_d;
    logic [3:0]           opc_q, opc_d;
    logic                 qneg_q, qneg_d;
    logic                 rneg_q, rneg_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Decoded view of the incoming request, only meaningful while start is sampled
    logic                 is_long;
    logic                 is_div;
    logic                 is_sdiv;
    logic                 is_rem;
    logic                 b_zero;
    logic                 div_ovf;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH-1:0]     quick_res;
    logic [WIDTH-1:0]     special_res;

    // Engine step and final-result shaping
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_rshift;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   step_acc;
    logic [WIDTH-1:0]     final_res;

    // Request decode: opcodes A-F are iterative, C-F divide, even C/E signed, E/F remainder
    always_comb begin
        is_long = opc[3] & (opc[2] | opc[1]);
        is_div  = opc[3] & opc[2];
        is_sdiv = is_div & ~opc[0];
        is_rem  = is_div & opc[1];
        b_zero  = (B == '0);
        div_ovf = is_sdiv && (A == MIN_INT) && (B == '1);
        a_mag   = (is_sdiv && A[WIDTH-1]) ? (~A + 1'b1) : A;
        b_mag   = (is_sdiv && B[WIDTH-1]) ? (~B + 1'b1) : B;
        if (b_zero) begin
            special_res = is_rem ? A : '1;
        end else begin
            special_res = is_rem ? '0 : A;
        end
    end

    // Single-cycle operations (opc 0-9); shifts use only the low SHW bits of B
    always_comb begin
        quick_res = '0;
        case (opc)
            4'h0: quick_res = A + B;
            4'h1: quick_res = A - B;
            4'h2: quick_res = A & B;
            4'h3: quick_res = A | B;
            4'h4: quick_res = A ^ B;
            4'h5: quick_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            4'h6: quick_res = {{(WIDTH-1){1'b0}}, (A < B)};
            4'h7: quick_res = A << B[SHW-1:0];
            4'h8: quick_res = A >> B[SHW-1:0];
            4'h9: quick_res = $unsigned($signed(A) >>> B[SHW-1:0]);
            default: quick_res = '0;
        endcase
    end

    // One engine iteration: shift-add multiply or restoring divide on the shared accumulator
    always_comb begin
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        mul_next   = {mul_sum, acc_q[WIDTH-1:1]};
        div_rshift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff   = div_rshift - {1'b0, opd_q};
        if (div_rshift >= {1'b0, opd_q}) begin
            div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {acc_q[2*WIDTH-2:0], 1'b0};
        end
        step_acc = opc_q[2] ? div_next : mul_next;
    end

    // Final result from the last iteration, with the signed fix-up folded into the same cycle
    always_comb begin
        final_res = '0;
        case (opc_q)
            4'hA:        final_res = step_acc[WIDTH-1:0];
            4'hB:        final_res = step_acc[2*WIDTH-1:WIDTH];
            4'hC, 4'hD:  final_res = qneg_q ? (~step_acc[WIDTH-1:0] + 1'b1)
                                            : step_acc[WIDTH-1:0];
            4'hE, 4'hF:  final_res = rneg_q ? (~step_acc[2*WIDTH-1:WIDTH] + 1'b1)
                                            : step_acc[2*WIDTH-1:WIDTH];
            default:     final_res = '0;
        endcase
    end

    // Next-state logic for the IDLE/CALC/DONE handshake and engine registers
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        opc_d    = opc_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    opc_d = opc;
                    if (!is_long) begin
                        result_d = quick_res;
                        state_d  = DONE;
                        done_d   = 1'b1;
                    end else if (is_div && (b_zero || div_ovf)) begin
                        result_d = special_res;
                        state_d  = DONE;
                        done_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                        busy_d  = 1'b1;
                        cnt_d   = SHW'(WIDTH-1);
                        acc_d   = {{WIDTH{1'b0}}, (is_div ? a_mag : B)};
                        opd_d   = is_div ? b_mag : A;
                        qneg_d  = is_sdiv & (A[WIDTH-1] ^ B[WIDTH-1]);
                        rneg_d  = is_sdiv & A[WIDTH-1];
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                acc_d = step_acc;
                if (cnt_q == '0) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = final_res;
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            opc_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            opc_q    <= opc_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign zero   = (result_q == '0);
    assign neg    = result_q[WIDTH-1];

endmodule
